// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the bit-serial arithmetic FSM family
// (adder today, subtractor later).
package serial_arith_pkg;

  // Control states common to every serial arithmetic unit.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ser_state_t;

  // Bit-counter width for a given operand width.
  // Never returns less than one bit, so WIDTH=2 still gets a real counter.
  function automatic int ser_cnt_width(input int width);
    if (width <= 2) begin
      return 1;
    end else begin
      return $clog2(width);
    end
  endfunction

endpackage : serial_arith_pkg

// File: rtl/full_adder_df.sv
// Single-bit full adder, pure dataflow.
// This is the only arithmetic cell the serial adder uses.
module full_adder_df (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic half_s;

  assign half_s = a ^ b;
  assign sum    = half_s ^ cin;
  assign cout   = (a & b) | (cin & half_s);

endmodule : full_adder_df

// File: rtl/serial_adder_fsm.sv
// Bit-serial WIDTH-bit adder.
// Operands are captured on an accepted start and added LSB-first, one bit per
// clock, through one full-adder cell. The result is presented with a
// single-cycle done pulse and then held until the next completion.
module serial_adder_fsm
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int            CW       = ser_cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  ser_state_t       state_q,  state_d;
  logic [WIDTH-1:0] a_sh_q,   a_sh_d;
  logic [WIDTH-1:0] b_sh_q,   b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q,  carry_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic [WIDTH-1:0] sum_q,    sum_d;
  logic             cout_q,   cout_d;

  logic             fa_sum_s;
  logic             fa_cout_s;

  // The one full-adder cell, always looking at the current LSBs and carry.
  full_adder_df u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum_s),
    .cout (fa_cout_s)
  );

  // Next-state logic: operand capture, per-bit shifting and result hand-off.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    sum_d    = sum_q;
    cout_d   = cout_q;

    case (state_q)
      IDLE, DONE: begin
        // DONE accepts a new request exactly like IDLE, giving back-to-back ops.
        if (start) begin
          a_sh_d   = a;
          b_sh_d   = b;
          sum_sh_d = {WIDTH{1'b0}};
          carry_d  = cin;
          cnt_d    = {CW{1'b0}};
          busy_d   = 1'b1;
          state_d  = RUN;
        end else begin
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
      end

      RUN: begin
        // start is deliberately not looked at here.
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        sum_sh_d = {fa_sum_s, sum_sh_q[WIDTH-1:1]};
        carry_d  = fa_cout_s;
        if (cnt_q == CNT_LAST) begin
          // Last bit: publish the completed word and leave RUN.
          sum_d   = {fa_sum_s, sum_sh_q[WIDTH-1:1]};
          cout_d  = fa_cout_s;
          cnt_d   = {CW{1'b0}};
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end

      default: begin
        // Unreachable encoding: fall back to a quiet IDLE.
        busy_d  = 1'b0;
        done_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= {WIDTH{1'b0}};
      b_sh_q   <= {WIDTH{1'b0}};
      sum_sh_q <= {WIDTH{1'b0}};
      carry_q  <= 1'b0;
      cnt_q    <= {CW{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sum_q    <= {WIDTH{1'b0}};
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule : serial_adder_fsm

// File: tb/tb_serial_adder_fsm.sv
// Self-checking bench for serial_adder_fsm.
// An 8-bit and a 16-bit instance are compared every cycle against an
// operation-level model, plus literal expectations for the directed cases.
module tb_serial_adder_fsm;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic        start0 = 1'b0;
  logic [7:0]  a0 = 8'h00;
  logic [7:0]  b0 = 8'h00;
  logic        cin0 = 1'b0;
  logic        busy0, done0, cout0;
  logic [7:0]  sum0;

  logic        start1 = 1'b0;
  logic [15:0] a1 = 16'h0000;
  logic [15:0] b1 = 16'h0000;
  logic        cin1 = 1'b0;
  logic        busy1, done1, cout1;
  logic [15:0] sum1;

  int n_chk  = 0;
  int n_fail = 0;

  // Operation-level model: cycles left, pending and published {cout,sum}.
  int          m_rem  [2] = '{0, 0};
  logic [32:0] m_pend [2] = '{33'd0, 33'd0};
  logic [32:0] m_res  [2] = '{33'd0, 33'd0};
  logic        m_busy [2] = '{1'b0, 1'b0};
  logic        m_done [2] = '{1'b0, 1'b0};
  int          ops    [2] = '{0, 0};

  serial_adder_fsm #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0), .cin(cin0),
    .busy(busy0), .done(done0), .sum(sum0), .cout(cout0)
  );

  serial_adder_fsm #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock edge of the model: a request is taken when no op is in flight;
  // the result appears w edges later.
  task automatic model_step(input int i, input int w, input logic st,
                            input logic [31:0] av, input logic [31:0] bv, input logic c);
    if (m_rem[i] > 0) begin
      m_rem[i] = m_rem[i] - 1;
      if (m_rem[i] == 0) begin
        m_res[i]  = m_pend[i];
        m_done[i] = 1'b1;
      end else begin
        m_done[i] = 1'b0;
      end
      m_busy[i] = (m_rem[i] > 0);
    end else begin
      m_done[i] = 1'b0;
      if (st) begin
        m_pend[i] = 33'(av) + 33'(bv) + 33'(c);
        m_rem[i]  = w;
        m_busy[i] = 1'b1;
      end else begin
        m_busy[i] = 1'b0;
      end
    end
  endtask

  // Model advance on each edge; reset clears it immediately.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_rem[i]  = 0;
        m_pend[i] = 33'd0;
        m_res[i]  = 33'd0;
        m_busy[i] = 1'b0;
        m_done[i] = 1'b0;
      end
    end else begin
      model_step(0, 8,  start0, {24'd0, a0}, {24'd0, b0}, cin0);
      model_step(1, 16, start1, {16'd0, a1}, {16'd0, b1}, cin1);
    end
  end

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    chk("busy8", 64'(busy0), 64'(m_busy[0]));
    chk("done8", 64'(done0), 64'(m_done[0]));
    chk("res8",  64'({cout0, sum0}), 64'(m_res[0]));
    chk("busy16", 64'(busy1), 64'(m_busy[1]));
    chk("done16", 64'(done1), 64'(m_done[1]));
    chk("res16",  64'({cout1, sum1}), 64'(m_res[1]));
    if (m_done[0]) ops[0]++;
    if (m_done[1]) ops[1]++;
  end

  // Launch one 8-bit op from a negedge and follow it to the done cycle.
  // Returns with the bench sitting at the negedge inside the done cycle.
  task automatic op0(input logic [7:0] av, input logic [7:0] bv, input logic c,
                     input logic hold, output logic [8:0] res, output int nb, output int lat);
    a0 = av; b0 = bv; cin0 = c; start0 = 1'b1;
    @(negedge clk);
    lat = 1;
    nb  = busy0 ? 1 : 0;
    start0 = hold;
    a0 = 8'($urandom); b0 = 8'($urandom); cin0 = 1'($urandom);
    while (!done0 && lat < 40) begin
      @(negedge clk);
      lat++;
      a0 = 8'($urandom); b0 = 8'($urandom);
      if (!done0) nb += busy0 ? 1 : 0;
    end
    start0 = 1'b0;
    chk("done_seen", 64'(done0), 64'd1);
    res = {cout0, sum0};
  endtask

  initial begin
    logic [8:0] res;
    int nb, lat;

    // Asynchronous reset with no clock edge involved.
    #1 rst_n = 1'b0;
    #2;
    chk("rst_busy", 64'(busy0), 64'd0);
    chk("rst_done", 64'(done0), 64'd0);
    chk("rst_res",  64'({cout0, sum0}), 64'd0);
    chk("rst_res16", 64'({cout1, sum1}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 0F + 01: busy exactly 8 cycles, done on the 9th.
    op0(8'h0F, 8'h01, 1'b0, 1'b0, res, nb, lat);
    chk("t1_res", 64'(res), 64'h010);
    chk("t1_busy_cycles", 64'(nb), 64'd8);
    chk("t1_latency", 64'(lat), 64'd9);
    @(negedge clk);

    // Carry-out cases.
    op0(8'hFF, 8'h01, 1'b0, 1'b0, res, nb, lat);
    chk("t2_ff_01", 64'(res), 64'h100);
    @(negedge clk);
    op0(8'hFF, 8'hFF, 1'b1, 1'b0, res, nb, lat);
    chk("t2_ff_ff_1", 64'(res), 64'h1FF);
    @(negedge clk);

    // start held through RUN with changing operands is ignored.
    op0(8'h0F, 8'h01, 1'b0, 1'b1, res, nb, lat);
    chk("t3_res", 64'(res), 64'h010);
    chk("t3_busy_cycles", 64'(nb), 64'd8);
    @(negedge clk);

    // Back-to-back: request issued in the DONE cycle starts at once.
    op0(8'h01, 8'h02, 1'b0, 1'b0, res, nb, lat);
    chk("t4_first", 64'(res), 64'h003);
    a0 = 8'h12; b0 = 8'h34; cin0 = 1'b0; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    chk("t4_no_idle", 64'(busy0), 64'd1);
    lat = 1;
    while (!done0 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("t4_latency", 64'(lat), 64'd9);
    chk("t4_res", 64'({cout0, sum0}), 64'h046);
    @(negedge clk);

    // Reset during busy cycle 4 abandons the op.
    a0 = 8'hAA; b0 = 8'h55; cin0 = 1'b0; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_busy_before", 64'(busy0), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_busy", 64'(busy0), 64'd0);
    chk("t5_done", 64'(done0), 64'd0);
    chk("t5_res",  64'({cout0, sum0}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("t5_no_done", 64'(done0), 64'd0);
    end
    op0(8'h01, 8'h01, 1'b0, 1'b0, res, nb, lat);
    chk("t5_next", 64'(res), 64'h002);
    @(negedge clk);

    // Random traffic on both widths; the per-cycle compare does the checking.
    ops[0] = 0;
    ops[1] = 0;
    for (int cyc = 0; cyc < 40000 && (ops[0] < 1000 || ops[1] < 1000); cyc++) begin
      start0 = 1'($urandom);
      a0 = 8'($urandom); b0 = 8'($urandom); cin0 = 1'($urandom);
      start1 = 1'($urandom);
      a1 = 16'($urandom); b1 = 16'($urandom); cin1 = 1'($urandom);
      @(negedge clk);
    end
    start0 = 1'b0;
    start1 = 1'b0;
    chk("rand_ops8",  64'(ops[0] >= 1000), 64'd1);
    chk("rand_ops16", 64'(ops[1] >= 1000), 64'd1);
    repeat (20) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_serial_adder_fsm
